// File: rtl/aes_sbox_pkg.sv
// Shared constants and GF(2^8) helpers for the masked AES S-box array.
// Optional feature macro: INV_SBOX_EN (inverse S-box mapping).
package aes_sbox_pkg;

    // Number of advances from batch acceptance until it appears at the output.
    localparam int unsigned LATENCY = 5;
    // Number of masked GF(2^8) multiplications in the x^254 inversion chain.
    localparam int unsigned NMULT = 4;
    // Affine constant of the forward S-box.
    localparam logic [7:0] AFF_CONST = 8'h63;
`ifdef INV_SBOX_EN
    // Inverse-affine matrix applied to 0x63; folded into share 0 on entry.
    localparam logic [7:0] INV_AFF_CONST = 8'h05;
`endif

    // Select codes for the per-share linear maps.
    typedef enum logic [1:0] {
        LM_IDENT   = 2'd0,
        LM_AFF     = 2'd1,
        LM_INV_AFF = 2'd2
    } lin_sel_e;

    // Fresh random bits needed per lane and per advance for a given share count.
    function automatic int unsigned sbox_nrnd(int unsigned shares);
        return NMULT * 8 * ((shares * (shares - 1)) / 2);
    endfunction

    // Index of the random byte shared by the unordered share pair (i, j), i < j.
    function automatic int unsigned pair_idx(int unsigned i, int unsigned j, int unsigned shares);
        return i * shares - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    // GF(2^8) multiplication modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    // GF(2)-linear byte maps (no constants); applied to every share independently.
    function automatic logic [7:0] lin_map(lin_sel_e sel, logic [7:0] x);
        logic [7:0] y;
        y = x;
        case (sel)
            LM_AFF:     y = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]};
`ifdef INV_SBOX_EN
            LM_INV_AFF: y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]};
`endif
            default:    y = x;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/masked_sbox_core.sv
// One masked S-box lane: linear entry map, shared inversion x^254 via four
// domain-oriented multiplications, linear exit map. Five register stages.
// Optional feature macro: INV_SBOX_EN (mode inputs select inverse mapping).
module masked_sbox_core
    import aes_sbox_pkg::*;
#(
    parameter int unsigned SHARES = 2
) (
    input  logic                         ClkxCI,
    input  logic                         RstxBI,
    input  logic                         EnablexSI,
    input  logic                         ClearxSI,
    input  logic                         InModexSI,
    input  logic                         ExitModexSI,
    input  logic                         ExitValidxSI,
    input  logic [8*SHARES-1:0]          InDataxDI,
    input  logic [sbox_nrnd(SHARES)-1:0] RandomxDI,
    output logic [8*SHARES-1:0]          OutDataxDO
);

    localparam int unsigned NPAIR = (SHARES * (SHARES - 1)) / 2;
    localparam int unsigned ZW    = 8 * NPAIR;

    typedef logic [SHARES-1:0][7:0] shr_t;

    // Shared product: each share gets its own term plus all cross terms,
    // with one fresh byte per share pair so the masks cancel on recombination.
    function automatic shr_t dom_mul(shr_t a, shr_t b, logic [ZW-1:0] z);
        shr_t       c;
        logic [7:0] acc;
        for (int unsigned i = 0; i < SHARES; i++) begin
            acc = gf_mul(a[i], b[i]);
            for (int unsigned j = 0; j < SHARES; j++) begin
                if (j != i) begin
                    acc = acc ^ gf_mul(a[i], b[j])
                              ^ z[8 * pair_idx((i < j) ? i : j, (i < j) ? j : i, SHARES) +: 8];
                end
            end
            c[i] = acc;
        end
        return c;
    endfunction

    // Raise to 2^k: squaring is linear in GF(2^8) so it is applied share-wise.
    function automatic shr_t pow2k(shr_t a, int unsigned k);
        shr_t r;
        r = a;
        for (int unsigned n = 0; n < k; n++) begin
            for (int unsigned i = 0; i < SHARES; i++) begin
                r[i] = gf_mul(r[i], r[i]);
            end
        end
        return r;
    endfunction

    // Linear map on all shares, constant folded into share 0 only.
    function automatic shr_t map_shares(shr_t a, lin_sel_e sel, logic [7:0] c);
        shr_t r;
        for (int unsigned i = 0; i < SHARES; i++) begin
            r[i] = lin_map(sel, a[i]);
        end
        r[0] = r[0] ^ c;
        return r;
    endfunction

    lin_sel_e   inSel;
    lin_sel_e   outSel;
    logic [7:0] inConst;
    logic [7:0] outConst;

    shr_t aInD, a2D, x3D, x12D, x15D, x240D, x252D, x254D, outD;
    shr_t x3Q, sq2Q0, x15Q, x12Q, sq2Q1, x252Q, sq2Q2, x254Q, outQ;

`ifndef INV_SBOX_EN
    logic unusedModes;
    assign unusedModes = InModexSI ^ ExitModexSI;
`endif

    // Entry map (identity or inverse affine) and first product x^3 = x * x^2.
    always_comb begin
        inSel   = LM_IDENT;
        inConst = 8'h00;
`ifdef INV_SBOX_EN
        if (InModexSI) begin
            inSel   = LM_INV_AFF;
            inConst = INV_AFF_CONST;
        end
`endif
        aInD = map_shares(shr_t'(InDataxDI), inSel, inConst);
        a2D  = pow2k(aInD, 1);
        x3D  = dom_mul(aInD, a2D, RandomxDI[0 +: ZW]);
    end

    // Remaining inversion chain: x^15, x^252, x^254.
    always_comb begin
        x12D  = pow2k(x3Q, 2);
        x15D  = dom_mul(x12D, x3Q, RandomxDI[ZW +: ZW]);
        x240D = pow2k(x15Q, 4);
        x252D = dom_mul(x240D, x12Q, RandomxDI[2 * ZW +: ZW]);
        x254D = dom_mul(x252Q, sq2Q2, RandomxDI[3 * ZW +: ZW]);
    end

    // Exit map (forward affine + 0x63, or identity); bubbles produce zero.
    always_comb begin
        outSel   = LM_AFF;
        outConst = AFF_CONST;
`ifdef INV_SBOX_EN
        if (ExitModexSI) begin
            outSel   = LM_IDENT;
            outConst = 8'h00;
        end
`endif
        outD = ExitValidxSI ? map_shares(x254Q, outSel, outConst) : '0;
    end

    // Pipeline registers; output stage cleared on flush so idle output reads zero.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            x3Q   <= '0;
            sq2Q0 <= '0;
            x15Q  <= '0;
            x12Q  <= '0;
            sq2Q1 <= '0;
            x252Q <= '0;
            sq2Q2 <= '0;
            x254Q <= '0;
            outQ  <= '0;
        end else if (ClearxSI) begin
            outQ  <= '0;
        end else if (EnablexSI) begin
            x3Q   <= x3D;
            sq2Q0 <= a2D;
            x15Q  <= x15D;
            x12Q  <= x12D;
            sq2Q1 <= sq2Q0;
            x252Q <= x252D;
            sq2Q2 <= sq2Q1;
            x254Q <= x254D;
            outQ  <= outD;
        end
    end

    assign OutDataxDO = outQ;

endmodule

// File: rtl/masked_sbox_array.sv
// NSBOX parallel masked AES S-box lanes sharing one valid/mode pipeline,
// gated by randomness availability and downstream backpressure.
// Optional feature macro: INV_SBOX_EN (honour InModexSI, inverse S-box).
module masked_sbox_array
    import aes_sbox_pkg::*;
#(
    parameter int unsigned SHARES = 2,
    parameter int unsigned NSBOX  = 4
) (
    input  logic                               ClkxCI,
    input  logic                               RstxBI,
    input  logic                               InValidxSI,
    output logic                               InReadyxSO,
    input  logic [8*SHARES*NSBOX-1:0]          InDataxDI,
    input  logic                               InModexSI,
    input  logic                               FlushxSI,
    input  logic                               RndValidxSI,
    output logic                               RndReadyxSO,
    input  logic [NSBOX*sbox_nrnd(SHARES)-1:0] RandomxDI,
    output logic                               OutValidxSO,
    input  logic                               OutReadyxSI,
    output logic [8*SHARES*NSBOX-1:0]          OutDataxDO,
    output logic                               OutModexSO,
    output logic                               BusyxSO,
    output logic [15:0]                        StallCntxDO
);

    localparam int unsigned RND_W  = sbox_nrnd(SHARES);
    localparam int unsigned LANE_W = 8 * SHARES;

    logic               advance;
    logic [LATENCY-1:0] validQ;
    logic [15:0]        stallCntQ;
    logic               entryMode;
    logic               exitMode;

    // Everything moves together only with fresh randomness and room at the output.
    assign advance     = RndValidxSI & ~FlushxSI & (~OutValidxSO | OutReadyxSI);
    assign InReadyxSO  = advance;
    assign RndReadyxSO = advance;
    assign OutValidxSO = validQ[LATENCY-1];
    assign BusyxSO     = |validQ;
    assign StallCntxDO = stallCntQ;

    // Valid shift register; flush drops every batch in flight.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            validQ <= '0;
        end else if (FlushxSI) begin
            validQ <= '0;
        end else if (advance) begin
            validQ <= {validQ[LATENCY-2:0], InValidxSI};
        end
    end

    // Saturating count of cycles starved for randomness while work is pending.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            stallCntQ <= '0;
        end else if ((InValidxSI | BusyxSO) & ~RndValidxSI & ~FlushxSI & (stallCntQ != 16'hFFFF)) begin
            stallCntQ <= stallCntQ + 16'd1;
        end
    end

`ifdef INV_SBOX_EN
    logic [LATENCY-1:0] modeQ;

    // Mode travels beside the valid bits; bubbles carry mode 0.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            modeQ <= '0;
        end else if (FlushxSI) begin
            modeQ <= '0;
        end else if (advance) begin
            modeQ <= {modeQ[LATENCY-2:0], InValidxSI & InModexSI};
        end
    end

    assign entryMode  = InModexSI;
    assign exitMode   = modeQ[LATENCY-2];
    assign OutModexSO = modeQ[LATENCY-1];
`else
    logic unusedMode;
    assign unusedMode = InModexSI;
    assign entryMode  = 1'b0;
    assign exitMode   = 1'b0;
    assign OutModexSO = 1'b0;
`endif

    // One masked core per lane, each with its own randomness slice.
    for (genvar l = 0; l < NSBOX; l++) begin : g_lane
        masked_sbox_core #(
            .SHARES(SHARES)
        ) u_core (
            .ClkxCI      (ClkxCI),
            .RstxBI      (RstxBI),
            .EnablexSI   (advance),
            .ClearxSI    (FlushxSI),
            .InModexSI   (entryMode),
            .ExitModexSI (exitMode),
            .ExitValidxSI(validQ[LATENCY-2]),
            .InDataxDI   (InDataxDI[l * LANE_W +: LANE_W]),
            .RandomxDI   (RandomxDI[l * RND_W +: RND_W]),
            .OutDataxDO  (OutDataxDO[l * LANE_W +: LANE_W])
        );
    end

endmodule

// File: tb/tb_masked_sbox_array.sv
// Self-checking bench for masked_sbox_array (SHARES=2, NSBOX=2).
// Works with or without INV_SBOX_EN defined.
module tb_masked_sbox_array;
    import aes_sbox_pkg::*;

    localparam int unsigned SHARES = 2;
    localparam int unsigned NSBOX  = 2;
    localparam int unsigned DW     = 8 * SHARES * NSBOX;
    localparam int unsigned RW     = NSBOX * sbox_nrnd(SHARES);
    localparam int unsigned XW     = 8 * NSBOX;
    localparam int          STAGES = 5;

    logic          ClkxCI = 1'b0;
    logic          RstxBI;
    logic          InValidxSI;
    logic          InReadyxSO;
    logic [DW-1:0] InDataxDI;
    logic          InModexSI;
    logic          FlushxSI;
    logic          RndValidxSI;
    logic          RndReadyxSO;
    logic [RW-1:0] RandomxDI;
    logic          OutValidxSO;
    logic          OutReadyxSI;
    logic [DW-1:0] OutDataxDO;
    logic          OutModexSO;
    logic          BusyxSO;
    logic [15:0]   StallCntxDO;

    masked_sbox_array #(
        .SHARES(SHARES),
        .NSBOX (NSBOX)
    ) dut (
        .ClkxCI     (ClkxCI),
        .RstxBI     (RstxBI),
        .InValidxSI (InValidxSI),
        .InReadyxSO (InReadyxSO),
        .InDataxDI  (InDataxDI),
        .InModexSI  (InModexSI),
        .FlushxSI   (FlushxSI),
        .RndValidxSI(RndValidxSI),
        .RndReadyxSO(RndReadyxSO),
        .RandomxDI  (RandomxDI),
        .OutValidxSO(OutValidxSO),
        .OutReadyxSI(OutReadyxSI),
        .OutDataxDO (OutDataxDO),
        .OutModexSO (OutModexSO),
        .BusyxSO    (BusyxSO),
        .StallCntxDO(StallCntxDO)
    );

    always #5 ClkxCI = ~ClkxCI;

    int checks   = 0;
    int failures = 0;
    int dutOuts  = 0;

    // Stimulus knobs for the next cycle.
    logic          iv, md, fl, rv, ordy;
    logic [XW-1:0] xs;
    logic          accepted;

    // Reference tables and pipeline occupancy model.
    logic [7:0]    sboxRef [256];
    logic [7:0]    invRef  [256];
    logic          mv [STAGES];
    logic          mm [STAGES];
    logic [XW-1:0] me [STAGES];
    logic [15:0]   mStall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Polynomial product reduced modulo the AES polynomial 0x11B.
    function automatic logic [7:0] ref_mul(logic [7:0] a, logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_sbox(logic [7:0] x);
        logic [7:0] inv, y, c;
        inv = 8'h00;
        for (int k = 1; k < 256; k++) if (ref_mul(x, 8'(k)) == 8'h01) inv = 8'(k);
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            y[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
        return y;
    endfunction

    function automatic logic [XW-1:0] unshare(logic [DW-1:0] d);
        logic [XW-1:0] r;
        r = '0;
        for (int l = 0; l < NSBOX; l++)
            for (int s = 0; s < SHARES; s++)
                r[l*8 +: 8] = r[l*8 +: 8] ^ d[(l*SHARES + s)*8 +: 8];
        return r;
    endfunction

    function automatic logic [XW-1:0] expect_out(logic [XW-1:0] x, logic m);
        logic [XW-1:0] r;
        for (int l = 0; l < NSBOX; l++) r[l*8 +: 8] = m ? invRef[x[l*8 +: 8]] : sboxRef[x[l*8 +: 8]];
        return r;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < STAGES; s++) begin
            mv[s] = 1'b0;
            mm[s] = 1'b0;
            me[s] = '0;
        end
    endtask

    // One clock cycle: drive, check against the model, step the model at the edge.
    task automatic tick();
        logic       adv, busyM, modeEff;
        logic [7:0] acc, r;
        InValidxSI  = iv;
        InModexSI   = md;
        FlushxSI    = fl;
        RndValidxSI = rv;
        OutReadyxSI = ordy;
        for (int l = 0; l < NSBOX; l++) begin
            acc = xs[l*8 +: 8];
            for (int s = 1; s < SHARES; s++) begin
                r = 8'($urandom());
                InDataxDI[(l*SHARES + s)*8 +: 8] = r;
                acc = acc ^ r;
            end
            InDataxDI[(l*SHARES)*8 +: 8] = acc;
        end
        for (int i = 0; i < RW / 8; i++) RandomxDI[i*8 +: 8] = 8'($urandom());
`ifdef INV_SBOX_EN
        modeEff = md;
`else
        modeEff = 1'b0;
`endif
        #1;
        busyM = 1'b0;
        for (int s = 0; s < STAGES; s++) busyM = busyM | mv[s];
        adv = rv & ~fl & (~mv[STAGES-1] | ordy);
        check("in_ready",  64'(InReadyxSO),  64'(adv));
        check("rnd_ready", 64'(RndReadyxSO), 64'(adv));
        check("busy",      64'(BusyxSO),     64'(busyM));
        check("out_valid", 64'(OutValidxSO), 64'(mv[STAGES-1]));
        check("out_mode",  64'(OutModexSO),  64'(mv[STAGES-1] & mm[STAGES-1]));
        if (mv[STAGES-1]) check("out_data", 64'(unshare(OutDataxDO)), 64'(me[STAGES-1]));
        else              check("out_zero", 64'(OutDataxDO), 64'h0);
        check("stall_cnt", 64'(StallCntxDO), 64'(mStall));
        if (OutValidxSO && OutReadyxSI && RndReadyxSO) dutOuts++;
        accepted = adv & iv;
        @(posedge ClkxCI);
        if ((iv | busyM) & ~rv & ~fl & (mStall != 16'hFFFF)) mStall = mStall + 16'd1;
        if (fl) begin
            model_clear();
        end else if (adv) begin
            for (int s = STAGES - 1; s > 0; s--) begin
                mv[s] = mv[s-1];
                mm[s] = mm[s-1];
                me[s] = me[s-1];
            end
            mv[0] = iv;
            mm[0] = iv & modeEff;
            me[0] = expect_out(xs, modeEff);
        end
        #1;
    endtask

    // Asynchronous reset pulse away from the clock edge; outputs must clear at once.
    task automatic do_reset();
        #1;
        RstxBI = 1'b0;
        #1;
        check("rst_busy",  64'(BusyxSO),     64'h0);
        check("rst_valid", 64'(OutValidxSO), 64'h0);
        check("rst_data",  64'(OutDataxDO),  64'h0);
        check("rst_stall", 64'(StallCntxDO), 64'h0);
        model_clear();
        mStall = 16'h0000;
        @(posedge ClkxCI);
        #1;
        RstxBI = 1'b1;
    endtask

    initial begin
        logic [XW-1:0] u;
        int            base, n;

        for (int x = 0; x < 256; x++) sboxRef[x] = ref_sbox(8'(x));
        for (int x = 0; x < 256; x++) invRef[sboxRef[x]] = 8'(x);

        RstxBI = 1'b0;
        InValidxSI = 1'b0; InModexSI = 1'b0; FlushxSI = 1'b0;
        RndValidxSI = 1'b0; OutReadyxSI = 1'b0;
        InDataxDI = '0; RandomxDI = '0;
        iv = 1'b0; md = 1'b0; fl = 1'b0; rv = 1'b1; ordy = 1'b1; xs = '0;
        model_clear();
        mStall = 16'h0000;
        #2;
        check("reset_valid", 64'(OutValidxSO), 64'h0);
        check("reset_busy",  64'(BusyxSO),     64'h0);
        check("reset_data",  64'(OutDataxDO),  64'h0);
        check("reset_stall", 64'(StallCntxDO), 64'h0);
        check("reset_mode",  64'(OutModexSO),  64'h0);
        @(posedge ClkxCI);
        #1;
        RstxBI = 1'b1;

        // Single batch of zeros: exact latency and 0x63 result.
        xs = '0; iv = 1'b1; tick(); iv = 1'b0;
        repeat (3) tick();
        check("lat_early", 64'(OutValidxSO), 64'h0);
        tick();
        check("lat_valid", 64'(OutValidxSO), 64'h1);
        u = unshare(OutDataxDO);
        check("sbox_00", 64'(u[7:0]), 64'h63);
        tick();

        // Back-to-back batches come out in order.
        xs = {8'h10, 8'h53}; iv = 1'b1; tick();
        xs = {8'hFF, 8'h01}; tick(); iv = 1'b0;
        repeat (3) tick();
        u = unshare(OutDataxDO);
        check("seq_first", 64'(u[7:0]), 64'hED);
        check("seq_first_l1", 64'(u[15:8]), 64'hCA);
        tick();
        u = unshare(OutDataxDO);
        check("seq_second", 64'(u[7:0]), 64'h7C);
        check("seq_second_l1", 64'(u[15:8]), 64'h16);
        tick();

        // Eight batches with three cycles of output backpressure.
        base = dutOuts; n = 0; xs = XW'($urandom());
        for (int c = 0; c < 30; c++) begin
            ordy = !(c >= 7 && c < 10);
            iv = (n < 8);
            tick();
            if (accepted) begin
                n++;
                xs = XW'($urandom());
            end
        end
        iv = 1'b0; ordy = 1'b1;
        check("bp_count", 64'(dutOuts - base), 64'd8);

        // Randomness starvation for four cycles mid-stream.
        do_reset();
        n = 0; xs = XW'($urandom());
        for (int c = 0; c < 20; c++) begin
            rv = !(c >= 2 && c < 6);
            iv = (n < 6);
            tick();
            if (accepted) begin
                n++;
                xs = XW'($urandom());
            end
        end
        rv = 1'b1; iv = 1'b0;
        check("stall_four", 64'(StallCntxDO), 64'd4);

`ifdef INV_SBOX_EN
        // Inverse mode round-trips the forward results.
        md = 1'b1;
        xs = {8'h63, 8'hED}; iv = 1'b1; tick();
        xs = {8'hED, 8'h63}; tick(); iv = 1'b0; md = 1'b0;
        repeat (3) tick();
        u = unshare(OutDataxDO);
        check("inv_first", 64'(u[7:0]), 64'h53);
        check("inv_first_l1", 64'(u[15:8]), 64'h00);
        check("inv_mode", 64'(OutModexSO), 64'h1);
        tick();
        u = unshare(OutDataxDO);
        check("inv_second", 64'(u[7:0]), 64'h00);
        tick();
`else
        // Mode input has no effect without the inverse feature.
        md = 1'b1;
        xs = {8'h01, 8'h53}; iv = 1'b1; tick(); iv = 1'b0; md = 1'b0;
        repeat (4) tick();
        u = unshare(OutDataxDO);
        check("fwd_only", 64'(u[7:0]), 64'hED);
        check("fwd_mode", 64'(OutModexSO), 64'h0);
        tick();
`endif

        // Flush with three batches in flight; flush beats a simultaneous input.
        base = dutOuts;
        iv = 1'b1;
        repeat (3) begin xs = XW'($urandom()); tick(); end
        fl = 1'b1; tick(); fl = 1'b0; iv = 1'b0;
        check("flush_busy", 64'(BusyxSO), 64'h0);
        repeat (8) tick();
        check("flush_no_out", 64'(dutOuts - base), 64'h0);

        // Reset with three batches in flight.
        base = dutOuts;
        iv = 1'b1;
        repeat (3) begin xs = XW'($urandom()); tick(); end
        iv = 1'b0;
        do_reset();
        repeat (8) tick();
        check("rst_no_out", 64'(dutOuts - base), 64'h0);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            iv   = 1'($urandom_range(0, 1));
            md   = 1'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 31) == 0);
            rv   = ($urandom_range(0, 9) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            xs   = XW'($urandom());
            tick();
        end
        iv = 1'b0; fl = 1'b0; rv = 1'b1; ordy = 1'b1; md = 1'b0;
        repeat (8) tick();
        check("drain_idle", 64'(BusyxSO), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/masked_sbox_array.md
MASKED_SBOX_ARRAY -- requirements
Module: masked_sbox_array

Interface
REQ-001 SHALL have parameter SHARES, default 2, number of Boolean shares per byte (>=2).
REQ-002 SHALL have parameter NSBOX, default 4, number of parallel S-box lanes (1..16).
REQ-003 SHALL have port ClkxCI  in  1  the single clock; all state is rising-edge.
REQ-004 SHALL have port RstxBI  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port InValidxSI  in  1  input batch valid.
REQ-006 SHALL have port InReadyxSO  out  1  input batch accepted this cycle.
REQ-007 SHALL have port InDataxDI  in  8*SHARES*NSBOX  shared bytes, lane l share i at bits [(l*SHARES+i)*8 +: 8].
REQ-008 SHALL have port InModexSI  in  1  0 forward S-box, 1 inverse S-box.
REQ-009 SHALL have port FlushxSI  in  1  synchronous pipeline flush.
REQ-010 SHALL have port RndValidxSI  in  1  fresh randomness available.
REQ-011 SHALL have port RndReadyxSO  out  1  randomness consumed this cycle.
REQ-012 SHALL have port RandomxDI  in  NSBOX*RND_W  fresh randomness, RND_W from package per SHARES.
REQ-013 SHALL have port OutValidxSO  out  1  output batch valid.
REQ-014 SHALL have port OutReadyxSI  in  1  downstream accepts output.
REQ-015 SHALL have port OutDataxDO  out  8*SHARES*NSBOX  shared S-box results, same packing as input.
REQ-016 SHALL have port OutModexSO  out  1  mode travelling with the output batch.
REQ-017 SHALL have port BusyxSO  out  1  any batch in flight.
REQ-018 SHALL have port StallCntxDO  out  16  saturating randomness-starvation counter.

Function
REQ-019 Advance SHALL be RndValidxSI & ~FlushxSI & (~OutValidxSO | OutReadyxSI); all pipeline registers (data, valid, mode) update only on advance.
REQ-020 InReadyxSO and RndReadyxSO SHALL both equal advance; a batch is accepted iff InValidxSI & advance.
REQ-021 Latency SHALL be exactly LATENCY=5 advances from acceptance to OutValidxSO; with advance every cycle, back-to-back batches give one result per cycle, in order.
REQ-022 A 5-bit valid shift register SHALL load InValidxSI at stage 0 on advance; OutValidxSO is stage 4.
REQ-023 The mode bit SHALL travel in a parallel 5-stage shift register; each lane's core selects forward/inverse mapping from the mode of its own stage.
REQ-024 Unshared, lane result SHALL equal AES SubBytes(x) (mode 0) or InvSubBytes(x) (mode 1); constant 0x63 applied to share 0 only.
REQ-025 OutDataxDO and OutModexSO SHALL be all-zero whenever OutValidxSO=0.
REQ-026 Randomness SHALL never be reused: each advance consumes RandomxDI once; no advance occurs without RndValidxSI.
REQ-027 FlushxSI=1 SHALL clear all valid bits at the next edge; input and randomness not consumed that cycle; flush wins over simultaneous input.
REQ-028 BusyxSO SHALL be OR of all valid bits.
REQ-029 StallCntxDO SHALL increment, saturating at 0xFFFF, each cycle where (InValidxSI | BusyxSO) & ~RndValidxSI & ~FlushxSI.

Reset
REQ-030 On RstxBI=0, valid/mode registers, StallCntxDO and all data registers SHALL clear to 0 immediately; OutValidxSO=0, BusyxSO=0, OutDataxDO=0 during and after reset until a batch completes.
REQ-031 Reset mid-operation SHALL drop all in-flight batches with no output.

Configuration
REQ-032 Macro INV_SBOX_EN defined: InModexSI honoured, inverse mapping matrices and mode pipeline present.
REQ-033 INV_SBOX_EN undefined: InModexSI ignored, mode pipeline absent, OutModexSO tied 0, forward S-box only.

Structure
REQ-034 Package aes_sbox_pkg SHALL hold LATENCY, affine constant 0x63, lin_map matrix select codes, and function sbox_nrnd(SHARES) giving RND_W.
REQ-035 One sub-module masked_sbox_core (one lane, enable input, mode input) SHALL be instantiated NSBOX times.

Verification
REQ-036 SHARES=2, NSBOX=1, lane shares 0x5A/0x5A (x=0x00), rnd always valid -> OutValidxSO after 5 cycles, share XOR 0x63.
REQ-037 x=0x53, x=0x01 back-to-back -> consecutive outputs 0xED, 0x7C, in order.
REQ-038 OutReadyxSI low 3 cycles during stream of 8 batches -> InReadyxSO low those cycles, no loss/duplication, order kept.
REQ-039 RndValidxSI low 4 cycles mid-stream -> pipeline frozen, StallCntxDO=4, results unchanged.
REQ-040 INV_SBOX_EN, mode 1, x=0xED and 0x63 -> 0x53 and 0x00; OutModexSO=1.
REQ-041 FlushxSI or RstxBI low with 3 batches in flight -> BusyxSO=0, no OutValidxSO afterwards.
